// File: rtl/demux32_1to4_dispatch_pkg.sv
// Shared constants for the 1-to-4 result dispatcher.
package demux32_1to4_dispatch_pkg;

  // Channel indices; bit k of out_valid/out_ready belongs to channel k.
  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;
  localparam int NUM_CH = 4;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 2;
  localparam int COUNT_W = 16;

endpackage

// File: rtl/demux32_1to4_dispatch_fifo.sv
// Per-destination synchronous FIFO. It has no bypass, and flush clears the
// occupancy but leaves storage intact.
module dispatch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q;
  logic                        do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  // Pop only when a word is present. Push is also gated by full here, so a
  // bad caller cannot corrupt the FIFO. The top already gates push with in_ready.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Head word comes straight from the registered storage at the read pointer.
  assign data_out_o = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy. Flush takes priority over push and pop.
  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_in_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/demux32_1to4_dispatch.sv
// Buffered 1-to-4 dispatcher. It routes each accepted word by in_sel into
// one of four FIFOs. Each FIFO drains independently.
module demux32_1to4_dispatch
  import demux32_1to4_dispatch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data_a,
  output logic [WIDTH-1:0]   out_data_b,
  output logic [WIDTH-1:0]   out_data_c,
  output logic [WIDTH-1:0]   out_data_d,
  output logic [NUM_CH-1:0]  out_valid,
  input  logic [NUM_CH-1:0]  out_ready,
  output logic [COUNT_W-1:0] accept_count
);

  logic [NUM_CH-1:0]            push_en, fifo_empty, fifo_full;
  logic [NUM_CH-1:0][WIDTH-1:0] fifo_dout;
  logic                         accept;
  logic [COUNT_W-1:0]           accept_count_q, accept_count_d;

  // in_ready looks only at the occupancy of the selected FIFO. It ignores
  // out_ready, so a full FIFO refuses a word even in a cycle when it pops.
  assign in_ready = !fifo_full[in_sel] && Rst_n && !flush;
  assign accept   = in_valid && in_ready;

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      assign push_en[k] = accept && (in_sel == 2'(k));

      dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_i      (Clk),
        .rst_n_i    (Rst_n),
        .push_i     (push_en[k]),
        .pop_i      (out_ready[k]),
        .flush_i    (flush),
        .data_in_i  (in_data),
        .data_out_o (fifo_dout[k]),
        .empty_o    (fifo_empty[k]),
        .full_o     (fifo_full[k])
      );
    end
  endgenerate

  assign out_valid  = ~fifo_empty;
  assign out_data_a = fifo_dout[CH_A];
  assign out_data_b = fifo_dout[CH_B];
  assign out_data_c = fifo_dout[CH_C];
  assign out_data_d = fifo_dout[CH_D];

  // Next value of the accepted-word counter. It wraps modulo 2^16.
  always_comb begin
    accept_count_d = accept_count_q;
    if (accept) accept_count_d = accept_count_q + COUNT_W'(1);
  end

  // The counter survives flush and is cleared only by reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) accept_count_q <= '0;
    else        accept_count_q <= accept_count_d;
  end

  assign accept_count = accept_count_q;

endmodule
